mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have: clk  in  1  single clock; all state rises on posedge clk.
REQ-002 The block SHALL have: rst_n  in  1  asynchronous, active-low reset.
REQ-003 The block SHALL have: ex_valid  in  1  the EX/MEM stage holds a valid instruction.
REQ-004 The block SHALL have: ex_rd / ex_wr  in  1 each  load / store request; both high is treated as a load.
REQ-005 The block SHALL have: ex_size  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
REQ-006 The block SHALL have: ex_unsigned  in  1  zero-extend loads when high, sign-extend when low.
REQ-007 The block SHALL have: ex_addr  in 32  byte address; ex_wdata  in 32  store data, right-justified.
REQ-008 The block SHALL have: ex_wb  in  7  writeback control, passed through to the MEM/WB side.
REQ-009 The block SHALL have: dmem_req, dmem_we  out 1; dmem_addr  out 32 (bits[1:0]=0); dmem_be  out 4; dmem_wdata  out 32.
REQ-010 The block SHALL have: dmem_ack  in 1  one-cycle completion pulse; dmem_rdata  in 32  valid when dmem_ack is high.
REQ-011 The block SHALL have: mem_stall  out 1  combinational; upstream holds all ex_* inputs stable while it is high.
REQ-012 The block SHALL have: wb_valid out 1; wb_data out 32; wb_ctrl out 7; misalign out 1. All registered.

Function
REQ-013 The FSM SHALL have two states, IDLE and ACCESS.
REQ-014 IDLE->ACCESS SHALL occur when ex_valid and (ex_rd or ex_wr); all other ex_valid instructions stay in IDLE and register through in 1 cycle: wb_valid=1, wb_ctrl=ex_wb, wb_data=ex_addr (ALU result).
REQ-015 On the IDLE->ACCESS transition the block SHALL register dmem_addr, dmem_we, dmem_be and dmem_wdata, and assert dmem_req from the next cycle.
REQ-016 In ACCESS, dmem_req and all dmem_* outputs SHALL be held constant until dmem_ack is seen.
REQ-017 On dmem_ack in ACCESS the block SHALL return to IDLE and register wb_valid=1 and wb_ctrl=ex_wb; for a load, wb_data=extended data; for a store, wb_data=0.
REQ-018 mem_stall SHALL equal (IDLE & ex_valid & memop) | (ACCESS & !dmem_ack).
REQ-019 The minimum memory-op latency SHALL be 2 cycles, from acceptance to the wb_valid edge.
REQ-020 dmem_be SHALL be: byte -> 0001<<addr[1:0]; half -> 0011<<{addr[1],0}; word -> 1111.
REQ-021 dmem_wdata SHALL be: byte replicated x4; half replicated x2; word as-is.
REQ-022 Load data SHALL be the lane selected by addr[1:0], then sign- or zero-extended to 32 bits.
REQ-023 wb_valid SHALL be a 1-cycle pulse per instruction; it is 0 in cycles with no completion.
REQ-024 When ex_valid=0 in IDLE, wb_valid SHALL be 0, and wb_ctrl and wb_data SHALL hold their prior values.
REQ-025 A dmem_ack received in IDLE SHALL be ignored.

Reset
REQ-026 When rst_n=0, the block SHALL immediately enter IDLE and drive dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0, wb_valid=0, wb_data=0, wb_ctrl=0, misalign=0.
REQ-027 A reset asserted in ACCESS SHALL abandon the access; a later dmem_ack is ignored per REQ-025.

Configuration
REQ-028 With macro MEM_ALIGN_CHECK_EN defined, a misaligned access SHALL NOT issue dmem_req; misalignment means half with addr[0]=1, or word with addr[1:0]!=0.
REQ-029 With MEM_ALIGN_CHECK_EN defined, such an access SHALL complete in 1 cycle with wb_valid=1, misalign=1, wb_ctrl=0 and wb_data=0.
REQ-030 Without MEM_ALIGN_CHECK_EN, the block SHALL ignore the offending low address bits (access is forced aligned) and tie misalign to 0.

Verification
REQ-031 Word store: addr=0x100, wdata=0xDEADBEEF, ack on 3rd ACCESS cycle -> req held 3 cycles, be=1111, mem_stall high 3 cycles, then wb_valid pulse.
REQ-032 Signed byte load: addr=0x103, rdata=0x80AABBCC -> be=1000, wb_data=0xFFFFFF80; with ex_unsigned=1 -> 0x00000080.
REQ-033 Half load: addr=0x202, rdata=0x1234ABCD, unsigned -> be=1100, wb_data=0x00001234.
REQ-034 Non-memory op: ex_wb=7'h45, ex_addr=0x55 -> next cycle wb_valid=1, wb_ctrl=0x45, wb_data=0x55, mem_stall=0, no dmem_req.
REQ-035 Reset mid-access: rst_n low for 1 cycle in ACCESS -> dmem_req=0 immediately, all outputs 0; a following dmem_ack produces no wb_valid.
REQ-036 Word load at addr=0x101: with MEM_ALIGN_CHECK_EN -> no req, misalign=1, wb_ctrl=0; without it -> dmem_addr=0x100, misalign=0.

Source files
------------

// File: rtl/mem_access_if.sv
// mem_access_if: EX/MEM request, data-memory handshake and MEM/WB result bundle.
// slave = memory access unit, master = pipeline/memory environment driving it.
interface mem_access_if;
    logic        ex_valid;
    logic        ex_rd;
    logic        ex_wr;
    logic [1:0]  ex_size;
    logic        ex_unsigned;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic [6:0]  ex_wb;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        mem_stall;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [6:0]  wb_ctrl;
    logic        misalign;

    modport master (
        output ex_valid, ex_rd, ex_wr, ex_size, ex_unsigned, ex_addr, ex_wdata, ex_wb,
        output dmem_ack, dmem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  mem_stall, wb_valid, wb_data, wb_ctrl, misalign
    );

    modport slave (
        input  ex_valid, ex_rd, ex_wr, ex_size, ex_unsigned, ex_addr, ex_wdata, ex_wb,
        input  dmem_ack, dmem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output mem_stall, wb_valid, wb_data, wb_ctrl, misalign
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: EX/MEM load/store sequencer with byte-lane steering and load extension.
// Optional macro MEM_ALIGN_CHECK_EN: misaligned half/word accesses trap instead of being forced aligned.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst_n,
    mem_access_if.slave bus
);
    typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t      state_r, state_nxt_s;
    logic        dmem_req_r, dmem_req_nxt_s;
    logic        dmem_we_r, dmem_we_nxt_s;
    logic [31:0] dmem_addr_r, dmem_addr_nxt_s;
    logic [3:0]  dmem_be_r, dmem_be_nxt_s;
    logic [31:0] dmem_wdata_r, dmem_wdata_nxt_s;
    logic        wb_valid_r, wb_valid_nxt_s;
    logic [31:0] wb_data_r, wb_data_nxt_s;
    logic [6:0]  wb_ctrl_r, wb_ctrl_nxt_s;
    logic        misalign_r, misalign_nxt_s;
    logic        memop_s;
    logic        misalign_s;
    logic [31:0] load_ext_s;

    function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] addr);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << addr;
            2'b01:   be = addr[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] rep;
        case (size)
            2'b00:   rep = {4{data[7:0]}};
            2'b01:   rep = {2{data[15:0]}};
            default: rep = data;
        endcase
        return rep;
    endfunction

    assign memop_s = bus.ex_rd | bus.ex_wr;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign_s = ((bus.ex_size == 2'b01) & bus.ex_addr[0]) |
                        (bus.ex_size[1] & (bus.ex_addr[1:0] != 2'b00));
`else
    assign misalign_s = 1'b0;
`endif

    // Lane pick from the returned word; ex_* are held stable while the access is pending.
    always_comb begin
        load_ext_s = bus.dmem_rdata;
        case (bus.ex_size)
            2'b00: begin
                load_ext_s[7:0]  = bus.dmem_rdata[{bus.ex_addr[1:0], 3'b000} +: 8];
                load_ext_s[31:8] = bus.ex_unsigned ? 24'h000000 : {24{load_ext_s[7]}};
            end
            2'b01: begin
                load_ext_s[15:0]  = bus.dmem_rdata[{bus.ex_addr[1], 4'b0000} +: 16];
                load_ext_s[31:16] = bus.ex_unsigned ? 16'h0000 : {16{load_ext_s[15]}};
            end
            default: load_ext_s = bus.dmem_rdata;
        endcase
    end

    // Next-state and next-output decode for the IDLE/ACCESS sequencer.
    always_comb begin
        state_nxt_s      = state_r;
        dmem_req_nxt_s   = dmem_req_r;
        dmem_we_nxt_s    = dmem_we_r;
        dmem_addr_nxt_s  = dmem_addr_r;
        dmem_be_nxt_s    = dmem_be_r;
        dmem_wdata_nxt_s = dmem_wdata_r;
        wb_valid_nxt_s   = 1'b0;
        wb_data_nxt_s    = wb_data_r;
        wb_ctrl_nxt_s    = wb_ctrl_r;
        misalign_nxt_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.ex_valid && memop_s && !misalign_s) begin
                    state_nxt_s      = ACCESS;
                    dmem_req_nxt_s   = 1'b1;
                    dmem_we_nxt_s    = bus.ex_wr & ~bus.ex_rd;
                    dmem_addr_nxt_s  = {bus.ex_addr[31:2], 2'b00};
                    dmem_be_nxt_s    = lane_enable(bus.ex_size, bus.ex_addr[1:0]);
                    dmem_wdata_nxt_s = lane_replicate(bus.ex_size, bus.ex_wdata);
                end else if (bus.ex_valid && memop_s) begin
                    wb_valid_nxt_s = 1'b1;
                    wb_data_nxt_s  = 32'h0000_0000;
                    wb_ctrl_nxt_s  = 7'h00;
                    misalign_nxt_s = 1'b1;
                end else if (bus.ex_valid) begin
                    wb_valid_nxt_s = 1'b1;
                    wb_data_nxt_s  = bus.ex_addr;
                    wb_ctrl_nxt_s  = bus.ex_wb;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCESS: begin
                if (bus.dmem_ack) begin
                    state_nxt_s    = IDLE;
                    dmem_req_nxt_s = 1'b0;
                    wb_valid_nxt_s = 1'b1;
                    wb_ctrl_nxt_s  = bus.ex_wb;
                    wb_data_nxt_s  = dmem_we_r ? 32'h0000_0000 : load_ext_s;
                end else begin
                    state_nxt_s = ACCESS;
                end
            end
            default: begin
                state_nxt_s    = IDLE;
                dmem_req_nxt_s = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any pending access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            dmem_req_r   <= 1'b0;
            dmem_we_r    <= 1'b0;
            dmem_addr_r  <= 32'h0000_0000;
            dmem_be_r    <= 4'b0000;
            dmem_wdata_r <= 32'h0000_0000;
            wb_valid_r   <= 1'b0;
            wb_data_r    <= 32'h0000_0000;
            wb_ctrl_r    <= 7'h00;
            misalign_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            dmem_req_r   <= dmem_req_nxt_s;
            dmem_we_r    <= dmem_we_nxt_s;
            dmem_addr_r  <= dmem_addr_nxt_s;
            dmem_be_r    <= dmem_be_nxt_s;
            dmem_wdata_r <= dmem_wdata_nxt_s;
            wb_valid_r   <= wb_valid_nxt_s;
            wb_data_r    <= wb_data_nxt_s;
            wb_ctrl_r    <= wb_ctrl_nxt_s;
            misalign_r   <= misalign_nxt_s;
        end
    end

    // Misaligned traps complete in the accept cycle, so they do not stall.
    assign bus.mem_stall  = ((state_r == IDLE) & bus.ex_valid & memop_s & ~misalign_s) |
                            ((state_r == ACCESS) & ~bus.dmem_ack);
    assign bus.dmem_req   = dmem_req_r;
    assign bus.dmem_we    = dmem_we_r;
    assign bus.dmem_addr  = dmem_addr_r;
    assign bus.dmem_be    = dmem_be_r;
    assign bus.dmem_wdata = dmem_wdata_r;
    assign bus.wb_valid   = wb_valid_r;
    assign bus.wb_data    = wb_data_r;
    assign bus.wb_ctrl    = wb_ctrl_r;
    assign bus.misalign   = misalign_r;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vectors with hand-computed expectations for mem_access_unit.
module tb_mem_access_unit;
    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fails  = 0;

    mem_access_if mif ();

    mem_access_unit u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive_ex(input logic rd, input logic wr, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata, input logic [6:0] wb);
        mif.ex_valid    = 1'b1;
        mif.ex_rd       = rd;
        mif.ex_wr       = wr;
        mif.ex_size     = size;
        mif.ex_unsigned = uns;
        mif.ex_addr     = addr;
        mif.ex_wdata    = wdata;
        mif.ex_wb       = wb;
    endtask

    task automatic idle_ex();
        mif.ex_valid = 1'b0;
        mif.ex_rd    = 1'b0;
        mif.ex_wr    = 1'b0;
    endtask

    // One memory op: wait_cyc ACCESS cycles without ack, then ack, then completion checks.
    task automatic run_mem(input string tag, input logic rd, input logic wr, input logic [1:0] size,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input logic [6:0] wb, input int wait_cyc,
                           input logic [3:0] exp_be, input logic [31:0] exp_addr,
                           input logic [31:0] exp_wdata, input logic [31:0] exp_wb_data);
        drive_ex(rd, wr, size, uns, addr, wdata, wb);
        #1;
        check_eq({tag, "_stall_accept"}, mif.mem_stall, 32'd1);
        check_eq({tag, "_req_accept"}, mif.dmem_req, 32'd0);
        for (int i = 0; i < wait_cyc; i++) begin
            @(posedge clk); #1;
            check_eq({tag, "_req_wait"}, mif.dmem_req, 32'd1);
            check_eq({tag, "_stall_wait"}, mif.mem_stall, 32'd1);
            check_eq({tag, "_be_wait"}, mif.dmem_be, exp_be);
        end
        @(posedge clk); #1;
        mif.dmem_ack   = 1'b1;
        mif.dmem_rdata = rdata;
        #1;
        check_eq({tag, "_stall_ack"}, mif.mem_stall, 32'd0);
        check_eq({tag, "_req"}, mif.dmem_req, 32'd1);
        check_eq({tag, "_we"}, mif.dmem_we, 32'(wr & ~rd));
        check_eq({tag, "_be"}, mif.dmem_be, exp_be);
        check_eq({tag, "_addr"}, mif.dmem_addr, exp_addr);
        check_eq({tag, "_wdata"}, mif.dmem_wdata, exp_wdata);
        check_eq({tag, "_wbv_early"}, mif.wb_valid, 32'd0);
        @(posedge clk); #1;
        mif.dmem_ack = 1'b0;
        idle_ex();
        check_eq({tag, "_wbv"}, mif.wb_valid, 32'd1);
        check_eq({tag, "_wbctrl"}, mif.wb_ctrl, 32'(wb));
        check_eq({tag, "_wbdata"}, mif.wb_data, exp_wb_data);
        check_eq({tag, "_misalign"}, mif.misalign, 32'd0);
        check_eq({tag, "_req_done"}, mif.dmem_req, 32'd0);
        @(posedge clk); #1;
        check_eq({tag, "_wbv_pulse"}, mif.wb_valid, 32'd0);
        check_eq({tag, "_wbdata_hold"}, mif.wb_data, exp_wb_data);
    endtask

    initial begin
        rst_n          = 1'b0;
        mif.ex_size     = 2'b00;
        mif.ex_unsigned = 1'b0;
        mif.ex_addr     = 32'h0;
        mif.ex_wdata    = 32'h0;
        mif.ex_wb       = 7'h00;
        mif.dmem_ack    = 1'b0;
        mif.dmem_rdata  = 32'h0;
        idle_ex();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_req", mif.dmem_req, 32'd0);
        check_eq("rst_be", mif.dmem_be, 32'd0);
        check_eq("rst_wbv", mif.wb_valid, 32'd0);
        check_eq("rst_stall", mif.mem_stall, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Word store, ack on third ACCESS cycle.
        run_mem("wst", 1'b0, 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 7'h11, 2,
                4'b1111, 32'h100, 32'hDEADBEEF, 32'h0);
        run_mem("lbs", 1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80AABBCC, 7'h22, 0,
                4'b1000, 32'h100, 32'h0, 32'hFFFFFF80);
        run_mem("lbu", 1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80AABBCC, 7'h23, 1,
                4'b1000, 32'h100, 32'h0, 32'h00000080);
        run_mem("lhu", 1'b1, 1'b0, 2'b01, 1'b1, 32'h202, 32'h0, 32'h1234ABCD, 7'h24, 0,
                4'b1100, 32'h200, 32'h0, 32'h00001234);
        run_mem("lhs", 1'b1, 1'b0, 2'b01, 1'b0, 32'h200, 32'h0, 32'h00008001, 7'h25, 0,
                4'b0011, 32'h200, 32'h0, 32'hFFFF8001);
        run_mem("sb", 1'b0, 1'b1, 2'b00, 1'b0, 32'h001, 32'h000000A5, 32'h0, 7'h26, 0,
                4'b0010, 32'h000, 32'hA5A5A5A5, 32'h0);
        run_mem("sh", 1'b0, 1'b1, 2'b01, 1'b0, 32'h106, 32'h1234BEEF, 32'h0, 7'h27, 0,
                4'b1100, 32'h104, 32'hBEEFBEEF, 32'h0);
        run_mem("rdwr", 1'b1, 1'b1, 2'b10, 1'b0, 32'h104, 32'h55555555, 32'hCAFEF00D, 7'h28, 0,
                4'b1111, 32'h104, 32'h55555555, 32'hCAFEF00D);
        run_mem("sz11", 1'b0, 1'b1, 2'b11, 1'b0, 32'h108, 32'h11223344, 32'h0, 7'h29, 0,
                4'b1111, 32'h108, 32'h11223344, 32'h0);

        // Non-memory op passes the ALU result through in one cycle.
        drive_ex(1'b0, 1'b0, 2'b10, 1'b0, 32'h55, 32'h0, 7'h45);
        #1;
        check_eq("alu_stall", mif.mem_stall, 32'd0);
        @(posedge clk); #1;
        idle_ex();
        check_eq("alu_wbv", mif.wb_valid, 32'd1);
        check_eq("alu_wbctrl", mif.wb_ctrl, 32'h45);
        check_eq("alu_wbdata", mif.wb_data, 32'h55);
        check_eq("alu_req", mif.dmem_req, 32'd0);
        @(posedge clk); #1;
        check_eq("alu_wbv_pulse", mif.wb_valid, 32'd0);
        check_eq("alu_wbctrl_hold", mif.wb_ctrl, 32'h45);
        check_eq("alu_wbdata_hold", mif.wb_data, 32'h55);

        // Stray ack in IDLE.
        mif.dmem_ack = 1'b1;
        @(posedge clk); #1;
        mif.dmem_ack = 1'b0;
        check_eq("idle_ack_wbv", mif.wb_valid, 32'd0);
        check_eq("idle_ack_req", mif.dmem_req, 32'd0);

`ifdef MEM_ALIGN_CHECK_EN
        drive_ex(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 7'h33);
        #1;
        check_eq("mis_stall", mif.mem_stall, 32'd0);
        @(posedge clk); #1;
        idle_ex();
        check_eq("mis_wbv", mif.wb_valid, 32'd1);
        check_eq("mis_flag", mif.misalign, 32'd1);
        check_eq("mis_wbctrl", mif.wb_ctrl, 32'd0);
        check_eq("mis_wbdata", mif.wb_data, 32'd0);
        check_eq("mis_req", mif.dmem_req, 32'd0);
        @(posedge clk); #1;
        check_eq("mis_req_after", mif.dmem_req, 32'd0);
`else
        run_mem("mis", 1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h01020304, 7'h33, 0,
                4'b1111, 32'h100, 32'h0, 32'h01020304);
`endif

        // Reset in ACCESS abandons the access; a later ack is ignored.
        drive_ex(1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 7'h3C);
        @(posedge clk); #1;
        check_eq("rma_req_pre", mif.dmem_req, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        idle_ex();
        check_eq("rma_req", mif.dmem_req, 32'd0);
        check_eq("rma_addr", mif.dmem_addr, 32'd0);
        check_eq("rma_be", mif.dmem_be, 32'd0);
        check_eq("rma_wbdata", mif.wb_data, 32'd0);
        check_eq("rma_wbctrl", mif.wb_ctrl, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mif.dmem_ack   = 1'b1;
        mif.dmem_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        mif.dmem_ack = 1'b0;
        check_eq("rma_ack_wbv", mif.wb_valid, 32'd0);
        check_eq("rma_ack_req", mif.dmem_req, 32'd0);
        @(posedge clk); #1;
        check_eq("rma_ack_wbv2", mif.wb_valid, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
